// File: rtl/emu_axil_pkg.sv
// Shared constants and types for the emulator control AXI4-Lite bridge.
package emu_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [3:0] STRB_FULL   = 4'hF;

   typedef enum logic [1:0] {
      ISSUE_NONE  = 2'd0,
      ISSUE_WRITE = 2'd1,
      ISSUE_READ  = 2'd2
   } issue_e;

endpackage

// File: rtl/emu_axil_hold_reg.sv
// One-entry valid/ready holding register; the consumer empties it with clear_i.
module emu_axil_hold_reg
   import emu_axil_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             accept_en_i,
   input  logic             clear_i,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;

   assign in_ready_o = ~full_q & accept_en_i;
   assign full_o     = full_q;
   assign data_o     = data_q;

   // Accept needs an empty entry and clear needs a full one, so they never coincide.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (in_valid_i && in_ready_o) begin
         full_d = 1'b1;
         data_d = in_data_i;
      end else if (clear_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) full_q <= 1'b0;
      else       full_q <= full_d;
   end

   always_ff @(posedge clk_i) begin
      data_q <= data_d;
   end

endmodule

// File: rtl/emu_ctrl_axil_bridge.sv
// AXI4-Lite slave that serialises host reads/writes onto single-cycle control
// register-bus strobes and returns the AXI responses.
module emu_ctrl_axil_bridge
   import emu_axil_pkg::*;
#(
   parameter int CTRL_ADDR_WIDTH = 32
) (
   input  logic                       host_clk,
   input  logic                       host_rst,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [CTRL_ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   input  logic [31:0]                s_axil_wdata,
   input  logic [3:0]                 s_axil_wstrb,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   output logic [1:0]                 s_axil_bresp,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   input  logic [CTRL_ADDR_WIDTH-1:0] s_axil_araddr,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready,
   output logic [31:0]                s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       ctrl_wen,
   output logic [CTRL_ADDR_WIDTH-1:0] ctrl_waddr,
   output logic [31:0]                ctrl_wdata,
   output logic                       ctrl_ren,
   output logic [CTRL_ADDR_WIDTH-1:0] ctrl_raddr,
   input  logic [31:0]                ctrl_rdata
);

   logic                       aw_full, w_full, ar_full;
   logic [CTRL_ADDR_WIDTH-1:0] aw_addr, ar_addr;
   logic [35:0]                w_entry;
   logic                       wr_elig, rd_elig;
   issue_e                     issue;

   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        rvalid_q, rvalid_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        last_wr_q, last_wr_d;

   emu_axil_hold_reg #(.WIDTH(CTRL_ADDR_WIDTH)) u_aw (
      .clk_i       (host_clk),
      .rst_i       (host_rst),
      .in_valid_i  (s_axil_awvalid),
      .in_ready_o  (s_axil_awready),
      .in_data_i   (s_axil_awaddr),
      .accept_en_i (~host_rst & ~bvalid_q),
      .clear_i     (issue == ISSUE_WRITE),
      .full_o      (aw_full),
      .data_o      (aw_addr)
   );

   emu_axil_hold_reg #(.WIDTH(36)) u_w (
      .clk_i       (host_clk),
      .rst_i       (host_rst),
      .in_valid_i  (s_axil_wvalid),
      .in_ready_o  (s_axil_wready),
      .in_data_i   ({s_axil_wstrb, s_axil_wdata}),
      .accept_en_i (~host_rst & ~bvalid_q),
      .clear_i     (issue == ISSUE_WRITE),
      .full_o      (w_full),
      .data_o      (w_entry)
   );

   emu_axil_hold_reg #(.WIDTH(CTRL_ADDR_WIDTH)) u_ar (
      .clk_i       (host_clk),
      .rst_i       (host_rst),
      .in_valid_i  (s_axil_arvalid),
      .in_ready_o  (s_axil_arready),
      .in_data_i   (s_axil_araddr),
      .accept_en_i (~host_rst & ~rvalid_q),
      .clear_i     (issue == ISSUE_READ),
      .full_o      (ar_full),
      .data_o      (ar_addr)
   );

   assign wr_elig = aw_full & w_full & ~bvalid_q;
   assign rd_elig = ar_full & ~rvalid_q;

   // On a tie the side that did not issue last wins; strobes are suppressed in reset.
   always_comb begin
      issue = ISSUE_NONE;
      if (!host_rst) begin
         if (wr_elig && (!rd_elig || !last_wr_q)) issue = ISSUE_WRITE;
         else if (rd_elig)                        issue = ISSUE_READ;
      end
   end

   assign ctrl_wen   = (issue == ISSUE_WRITE) && (w_entry[35:32] == STRB_FULL);
   assign ctrl_waddr = aw_addr;
   assign ctrl_wdata = w_entry[31:0];
   assign ctrl_ren   = (issue == ISSUE_READ);
   assign ctrl_raddr = ar_addr;

   always_comb begin
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      last_wr_d = last_wr_q;
      if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;
      if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
      if (issue == ISSUE_WRITE) begin
         bvalid_d  = 1'b1;
         bresp_d   = (w_entry[35:32] == STRB_FULL) ? RESP_OKAY : RESP_SLVERR;
         last_wr_d = 1'b1;
      end else if (issue == ISSUE_READ) begin
         rvalid_d  = 1'b1;
         rresp_d   = RESP_OKAY;
         rdata_d   = ctrl_rdata;
         last_wr_d = 1'b0;
      end
   end

   always_ff @(posedge host_clk) begin
      if (host_rst) begin
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         last_wr_q <= 1'b1;
      end else begin
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         last_wr_q <= last_wr_d;
      end
   end

   assign s_axil_bvalid = bvalid_q;
   assign s_axil_bresp  = bresp_q;
   assign s_axil_rvalid = rvalid_q;
   assign s_axil_rresp  = rresp_q;
   assign s_axil_rdata  = rdata_q;

endmodule

// File: tb/tb_emu_ctrl_axil_bridge.sv
// Bench for emu_ctrl_axil_bridge: transaction-queue reference model plus directed scenarios.
module tb_emu_ctrl_axil_bridge;

   logic        host_clk = 1'b0;
   logic        host_rst;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        ctrl_wen, ctrl_ren;
   logic [31:0] ctrl_waddr, ctrl_wdata, ctrl_raddr, ctrl_rdata;

   int errors = 0;
   int checks = 0;
   int wen_cnt = 0;
   int ren_cnt = 0;
   int w0;

   // Reference model: pending transactions per channel as queues
   logic [31:0] m_aw[$];
   logic [31:0] m_w[$];
   logic [3:0]  m_ws[$];
   logic [31:0] m_ar[$];
   logic [1:0]  m_b[$];
   logic [31:0] m_r[$];
   bit          m_last_wr = 1'b1;
   bit          acc_aw, acc_w, acc_ar;

   always #5 host_clk = ~host_clk;

   function automatic logic [31:0] reg_fn(input logic [31:0] a);
      return (a == 32'h8) ? 32'h1234_5678 : {a[15:0], ~a[15:0]};
   endfunction

   assign ctrl_rdata = reg_fn(ctrl_raddr);

   emu_ctrl_axil_bridge #(.CTRL_ADDR_WIDTH(32)) dut (
      .host_clk       (host_clk),
      .host_rst       (host_rst),
      .s_axil_awvalid (awvalid),
      .s_axil_awready (awready),
      .s_axil_awaddr  (awaddr),
      .s_axil_wvalid  (wvalid),
      .s_axil_wready  (wready),
      .s_axil_wdata   (wdata),
      .s_axil_wstrb   (wstrb),
      .s_axil_bvalid  (bvalid),
      .s_axil_bready  (bready),
      .s_axil_bresp   (bresp),
      .s_axil_arvalid (arvalid),
      .s_axil_arready (arready),
      .s_axil_araddr  (araddr),
      .s_axil_rvalid  (rvalid),
      .s_axil_rready  (rready),
      .s_axil_rdata   (rdata),
      .s_axil_rresp   (rresp),
      .ctrl_wen       (ctrl_wen),
      .ctrl_waddr     (ctrl_waddr),
      .ctrl_wdata     (ctrl_wdata),
      .ctrl_ren       (ctrl_ren),
      .ctrl_raddr     (ctrl_raddr),
      .ctrl_rdata     (ctrl_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare mid-cycle against the model, then advance the model across the clock edge.
   task automatic cycle();
      bit e_awr, e_wr, e_arr, wr_ok, rd_ok, full_strb;
      int pick;
      #4;
      e_awr = !host_rst && m_aw.size() == 0 && m_b.size() == 0;
      e_wr  = !host_rst && m_w.size() == 0 && m_b.size() == 0;
      e_arr = !host_rst && m_ar.size() == 0 && m_r.size() == 0;
      wr_ok = !host_rst && m_aw.size() != 0 && m_w.size() != 0 && m_b.size() == 0;
      rd_ok = !host_rst && m_ar.size() != 0 && m_r.size() == 0;
      pick = 0;
      if (wr_ok && rd_ok) pick = m_last_wr ? 2 : 1;
      else if (wr_ok)     pick = 1;
      else if (rd_ok)     pick = 2;
      full_strb = (pick == 1) && (m_ws[0] == 4'hF);

      chk("awready", {31'b0, awready}, {31'b0, e_awr});
      chk("wready", {31'b0, wready}, {31'b0, e_wr});
      chk("arready", {31'b0, arready}, {31'b0, e_arr});
      chk("ctrl_wen", {31'b0, ctrl_wen}, {31'b0, full_strb});
      chk("ctrl_ren", {31'b0, ctrl_ren}, {31'b0, pick == 2});
      chk("strobe_overlap", {31'b0, ctrl_wen & ctrl_ren}, 32'h0);
      if (full_strb) begin
         chk("ctrl_waddr", ctrl_waddr, m_aw[0]);
         chk("ctrl_wdata", ctrl_wdata, m_w[0]);
      end
      if (pick == 2) chk("ctrl_raddr", ctrl_raddr, m_ar[0]);
      chk("bvalid", {31'b0, bvalid}, {31'b0, m_b.size() != 0});
      if (m_b.size() != 0) chk("bresp", {30'b0, bresp}, {30'b0, m_b[0]});
      chk("rvalid", {31'b0, rvalid}, {31'b0, m_r.size() != 0});
      if (m_r.size() != 0) begin
         chk("rdata", rdata, m_r[0]);
         chk("rresp", {30'b0, rresp}, 32'h0);
      end
      if (ctrl_wen) wen_cnt++;
      if (ctrl_ren) ren_cnt++;

      acc_aw = awvalid && e_awr;
      acc_w  = wvalid && e_wr;
      acc_ar = arvalid && e_arr;
      if (host_rst) begin
         m_aw.delete(); m_w.delete(); m_ws.delete(); m_ar.delete();
         m_b.delete();  m_r.delete();
         m_last_wr = 1'b1;
      end else begin
         if (m_b.size() != 0 && bready) void'(m_b.pop_front());
         if (m_r.size() != 0 && rready) void'(m_r.pop_front());
         if (pick == 1) begin
            m_b.push_back(full_strb ? 2'b00 : 2'b10);
            void'(m_aw.pop_front()); void'(m_w.pop_front()); void'(m_ws.pop_front());
            m_last_wr = 1'b1;
         end else if (pick == 2) begin
            m_r.push_back(reg_fn(m_ar[0]));
            void'(m_ar.pop_front());
            m_last_wr = 1'b0;
         end
         if (acc_aw) m_aw.push_back(awaddr);
         if (acc_w) begin
            m_w.push_back(wdata);
            m_ws.push_back(wstrb);
         end
         if (acc_ar) m_ar.push_back(araddr);
      end
      @(posedge host_clk);
      #1;
   endtask

   initial begin
      host_rst = 1'b1;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
      awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
      @(posedge host_clk);
      #1;
      repeat (3) cycle();
      chk("rst_awready", {31'b0, awready}, 32'h0);
      chk("rst_bvalid", {31'b0, bvalid}, 32'h0);
      chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_bresp", {30'b0, bresp}, 32'h0);
      chk("rst_rresp", {30'b0, rresp}, 32'h0);
      host_rst = 1'b0;
      #1;
      chk("post_rst_awready", {31'b0, awready}, 32'h1);
      chk("post_rst_arready", {31'b0, arready}, 32'h1);

      // Full write, AW and W together
      awvalid = 1; awaddr = 32'h014; wvalid = 1; wdata = 32'hABCD_E000; wstrb = 4'hF;
      cycle();
      awvalid = 0; wvalid = 0;
      chk("w1_wen", {31'b0, ctrl_wen}, 32'h1);
      chk("w1_waddr", ctrl_waddr, 32'h014);
      chk("w1_wdata", ctrl_wdata, 32'hABCD_E000);
      cycle();
      chk("w1_bvalid", {31'b0, bvalid}, 32'h1);
      chk("w1_bresp", {30'b0, bresp}, 32'h0);
      chk("w1_wen_once", {31'b0, ctrl_wen}, 32'h0);
      bready = 1;
      cycle();
      bready = 0;

      // W three cycles ahead of AW
      w0 = wen_cnt;
      wvalid = 1; wdata = 32'h5555_AAAA; wstrb = 4'hF;
      cycle();
      wvalid = 0;
      repeat (3) cycle();
      chk("w2_no_early_wen", wen_cnt - w0, 32'h0);
      awvalid = 1; awaddr = 32'h020;
      cycle();
      awvalid = 0;
      chk("w2_wen", {31'b0, ctrl_wen}, 32'h1);
      cycle();
      bready = 1;
      cycle();
      bready = 0;
      chk("w2_one_strobe", wen_cnt - w0, 32'h1);

      // Read with response back-pressure
      arvalid = 1; araddr = 32'h008;
      cycle();
      arvalid = 0;
      chk("r1_ren", {31'b0, ctrl_ren}, 32'h1);
      chk("r1_raddr", ctrl_raddr, 32'h008);
      cycle();
      chk("r1_rdata", rdata, 32'h1234_5678);
      chk("r1_rresp", {30'b0, rresp}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("r1_hold_rvalid", {31'b0, rvalid}, 32'h1);
         chk("r1_hold_rdata", rdata, 32'h1234_5678);
      end
      rready = 1;
      cycle();
      chk("r1_done", {31'b0, rvalid}, 32'h0);
      rready = 0;

      // Partial strobe write
      awvalid = 1; awaddr = 32'h040; wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'h3;
      cycle();
      awvalid = 0; wvalid = 0;
      chk("w3_no_wen", {31'b0, ctrl_wen}, 32'h0);
      cycle();
      chk("w3_bvalid", {31'b0, bvalid}, 32'h1);
      chk("w3_bresp", {30'b0, bresp}, 32'h2);
      bready = 1;
      cycle();

      // Read and write eligible together
      rready = 1;
      for (int i = 0; i < 4; i++) begin
         awvalid = 1; awaddr = 32'h100 + 32'(i * 4); wvalid = 1; wdata = 32'(i); wstrb = 4'hF;
         arvalid = 1; araddr = 32'h200 + 32'(i * 4);
         cycle();
         awvalid = 0; wvalid = 0; arvalid = 0;
         chk("tie_first_is_read", {30'b0, ctrl_ren, ctrl_wen}, 32'h2);
         cycle();
         chk("tie_second_is_write", {30'b0, ctrl_ren, ctrl_wen}, 32'h1);
         repeat (3) cycle();
      end
      bready = 0; rready = 0;

      // Reset right after an AR handshake
      arvalid = 1; araddr = 32'h030;
      cycle();
      arvalid = 0;
      host_rst = 1;
      #1;
      chk("rst_ar_no_ren", {31'b0, ctrl_ren}, 32'h0);
      cycle();
      chk("rst_ar_no_rvalid", {31'b0, rvalid}, 32'h0);
      host_rst = 0;
      #1;
      chk("rst_ar_arready", {31'b0, arready}, 32'h1);

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         host_rst = ($urandom_range(0, 399) == 0);
         if (!awvalid || acc_aw) begin
            awvalid = ($urandom_range(0, 99) < 45);
            awaddr  = $urandom;
         end
         if (!wvalid || acc_w) begin
            wvalid = ($urandom_range(0, 99) < 45);
            wdata  = $urandom;
            wstrb  = ($urandom_range(0, 99) < 75) ? 4'hF : 4'($urandom);
         end
         if (!arvalid || acc_ar) begin
            arvalid = ($urandom_range(0, 99) < 45);
            araddr  = ($urandom_range(0, 9) == 0) ? 32'h8 : $urandom;
         end
         bready = ($urandom_range(0, 99) < 60);
         rready = ($urandom_range(0, 99) < 60);
         cycle();
      end
      chk("random_saw_writes", {31'b0, wen_cnt > 50}, 32'h1);
      chk("random_saw_reads", {31'b0, ren_cnt > 50}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/emu_ctrl_axil_bridge.md
# emu_ctrl_axil_bridge

AXI4-Lite slave that converts host MMIO transactions into the single-cycle register-bus strobes (`ctrl_wen`/`ctrl_waddr`/`ctrl_wdata`, `ctrl_ren`/`ctrl_raddr`/`ctrl_rdata`) consumed by the emulator system-control block. It sits between the host interconnect and the control register file. It buffers one transaction per AXI channel, serialises reads and writes onto the register bus, and returns AXI responses.

## Interface
- `CTRL_ADDR_WIDTH`, default 32: AXI address width and register-bus address width.
- `host_clk`  in  1  sole clock.
- `host_rst`  in  1  synchronous, active-high reset.
- `s_axil_awvalid`/`awready`  in/out  1  write-address handshake; `s_axil_awaddr`  in  CTRL_ADDR_WIDTH.
- `s_axil_wvalid`/`wready`  in/out  1  write-data handshake; `s_axil_wdata`  in  32; `s_axil_wstrb`  in  4.
- `s_axil_bvalid`/`bready`  out/in  1  write response; `s_axil_bresp`  out  2.
- `s_axil_arvalid`/`arready`  in/out  1  read-address handshake; `s_axil_araddr`  in  CTRL_ADDR_WIDTH.
- `s_axil_rvalid`/`rready`  out/in  1  read response; `s_axil_rdata`  out  32; `s_axil_rresp`  out  2.
- `ctrl_wen`  out  1  one-cycle register write strobe.
- `ctrl_waddr`  out  CTRL_ADDR_WIDTH  write address, valid with `ctrl_wen`.
- `ctrl_wdata`  out  32  write data, valid with `ctrl_wen`.
- `ctrl_ren`  out  1  one-cycle register read strobe.
- `ctrl_raddr`  out  CTRL_ADDR_WIDTH  read address, valid with `ctrl_ren`.
- `ctrl_rdata`  in  32  combinational read data for `ctrl_raddr`; sampled in the `ctrl_ren` cycle.

## Operation
- Holding registers: one entry each for AW, W and AR.
  - `awready` = AW entry empty and no B pending.
  - `wready` = W entry empty and no B pending.
  - `arready` = AR entry empty and no R pending.
  - AW and W are accepted independently, in either order or in the same cycle.
- Write eligible: AW and W entries both full and `bvalid` low. Read eligible: AR entry full and `rvalid` low.
- Issue: at most one of `ctrl_wen`/`ctrl_ren` is high in any cycle.
  - If only one is eligible, it issues.
  - If both are eligible, the grant alternates. A 1-bit `last_was_write` register resets to 1, so read wins the first tie.
- Write issue:
  - `wstrb == 4'hF`: `ctrl_wen`=1 with the buffered address and data. At that edge the AW and W entries clear, `bvalid` is set and `bresp` = OKAY (2'b00).
  - Any other `wstrb`: `ctrl_wen` stays 0. The entries clear and `bresp` = SLVERR (2'b10).
- Read issue: `ctrl_ren`=1 and `ctrl_raddr` = buffered address. At that edge `ctrl_rdata` is captured into `rdata`, the AR entry clears, `rvalid` is set and `rresp` = OKAY.
- `bvalid`/`rvalid` hold, with stable payload, until `bready`/`rready` is high at an edge. `ctrl_waddr`/`ctrl_wdata`/`ctrl_raddr` are don't-care when their strobe is low.
- Addresses pass through unmodified at full width; decoding belongs to the register file.

## Timing
- Reset values:
  - `bvalid`, `rvalid`, `ctrl_wen`, `ctrl_ren` = 0.
  - `bresp`, `rresp`, `rdata` = 0.
  - All holding entries empty; `last_was_write` = 1.
  - All readies are 0 while `host_rst` is high.
- Write latency: AW+W handshake at edge N → `ctrl_wen` in cycle N+1 (if granted) → `bvalid` from cycle N+2.
- Read latency: AR handshake at edge N → `ctrl_ren` in cycle N+1 → `rvalid` and `rdata` from cycle N+2.
- Back-to-back throughput:
  - One write per 3 cycles with `bready` tied high, because a new AW/W is blocked while B is pending.
  - Reads behave the same way.
- Reset mid-transaction: all entries and pending responses are dropped, with no strobe and no response. The register file may already have seen a strobe issued before the reset edge.
- A B or R handshake and a new AW/W/AR handshake cannot coincide, because the readies are gated by the pending response. The new handshake is accepted from the cycle after the response completes.

## Structure
- Shared package `emu_axil_pkg`:
  - `RESP_OKAY` = 2'b00, `RESP_SLVERR` = 2'b10.
  - `STRB_FULL` = 4'hF.
- Sub-module `emu_axil_hold_reg #(WIDTH)`: one-entry valid/ready holding register with a `clear` input. Instantiated three times (AW, W+strb, AR).
- Top level: issue arbiter, `last_was_write` register, B/R response registers.

## Test plan
- Write at 0x014 with data 0xABCD_E000, `wstrb` F, AW and W in the same cycle → `ctrl_wen` pulses once in cycle N+1 with address 0x014 and data 0xABCD_E000; `bresp` = 0 in N+2.
- W issued 3 cycles before AW → `ctrl_wen` is issued only after the AW handshake; exactly one strobe.
- Read at 0x008 with `ctrl_rdata` modelled as 0x1234_5678 → `ctrl_ren` pulses once; `rdata` = 0x1234_5678, `rresp` = 0; `rvalid` is held with `rready` low for 5 cycles, payload stable throughout.
- Write with `wstrb` = 4'h3 → no `ctrl_wen`; `bresp` = 2'b10.
- Read and write eligible in the same cycle, repeated 4 times → order is R, W, R, W; `ctrl_wen` and `ctrl_ren` are never high together.
- `host_rst` asserted the cycle after an AR handshake → no `ctrl_ren`; `rvalid` = 0; `arready` returns to 1 after reset.
